// File: rtl/mul_sched.sv
// Two-requester front end for a shared multiplier core.
// Round-robin grant, timeout on a silent core, result held until accepted.
module mul_sched #(
  parameter int WIDTH = 16,
  parameter int TMO   = 20
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req0_i,
  input  logic               req1_i,
  input  logic [WIDTH-1:0]   a0_i,
  input  logic [WIDTH-1:0]   b0_i,
  input  logic [WIDTH-1:0]   a1_i,
  input  logic [WIDTH-1:0]   b1_i,
  output logic               gnt0_o,
  output logic               gnt1_o,
  output logic               mul_start_o,
  output logic [WIDTH-1:0]   mul_a_o,
  output logic [WIDTH-1:0]   mul_b_o,
  input  logic               mul_done_i,
  input  logic [2*WIDTH-1:0] mul_p_i,
  output logic               res_valid_o,
  output logic               res_id_o,
  output logic [2*WIDTH-1:0] res_p_o,
  output logic               res_err_o,
  input  logic               res_ready_i,
  output logic               busy_o
);

  localparam int CW = (TMO > 1) ? $clog2(TMO + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  logic [1:0]    state;
  logic          owner;
  logic          last;
  logic [CW-1:0] cnt;
  logic          win;

  // Ties go to whoever was not granted last.
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      req0_i && req1_i:  win = ~last;
      req1_i && !req0_i: win = 1'b1;
      default:           win = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      cnt       <= '0;
      mul_a_o   <= '0;
      mul_b_o   <= '0;
      res_p_o   <= '0;
      res_err_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_i || req1_i) begin
            state   <= LOAD;
            owner   <= win;
            last    <= win;
            mul_a_o <= win ? a1_i : a0_i;
            mul_b_o <= win ? b1_i : b0_i;
          end
        end
        LOAD: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          if (mul_done_i) begin
            res_p_o   <= mul_p_i;
            res_err_o <= 1'b0;
            state     <= OUT;
          end else if (cnt == CW'(TMO - 1)) begin
            res_p_o   <= '0;
            res_err_o <= 1'b1;
            state     <= OUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        OUT: begin
          if (res_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt0_o      = (state == LOAD) && !owner;
  assign gnt1_o      = (state == LOAD) && owner;
  assign mul_start_o = (state == LOAD);
  assign res_valid_o = (state == OUT);
  assign res_id_o    = owner;
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_mul_sched.sv
// Bench for mul_sched: transaction-level model of grants,
// core latency, timeout and result handshake.
module tb_mul_sched;

  localparam int W   = 16;
  localparam int PW  = 2 * W;
  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic [W-1:0]  a0 = '0;
  logic [W-1:0]  b0 = '0;
  logic [W-1:0]  a1 = '0;
  logic [W-1:0]  b1 = '0;
  logic          gnt0;
  logic          gnt1;
  logic          mul_start;
  logic [W-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic          done = 1'b0;
  logic [PW-1:0] mul_p = '0;
  logic          res_valid;
  logic          res_id;
  logic [PW-1:0] res_p;
  logic          res_err;
  logic          ready = 1'b0;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit last_g = 1'b1;

  always #5 clk = ~clk;

  mul_sched #(.WIDTH(W), .TMO(TMO)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req0_i(req0),
    .req1_i(req1),
    .a0_i(a0),
    .b0_i(b0),
    .a1_i(a1),
    .b1_i(b1),
    .gnt0_o(gnt0),
    .gnt1_o(gnt1),
    .mul_start_o(mul_start),
    .mul_a_o(mul_a),
    .mul_b_o(mul_b),
    .mul_done_i(done),
    .mul_p_i(mul_p),
    .res_valid_o(res_valid),
    .res_id_o(res_id),
    .res_p_o(res_p),
    .res_err_o(res_err),
    .res_ready_i(ready),
    .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt0"}, gnt0, 0);
    chk({tag, "_gnt1"}, gnt1, 0);
    chk({tag, "_start"}, mul_start, 0);
    chk({tag, "_mul_a"}, mul_a, 0);
    chk({tag, "_mul_b"}, mul_b, 0);
    chk({tag, "_valid"}, res_valid, 0);
    chk({tag, "_id"}, res_id, 0);
    chk({tag, "_p"}, res_p, 0);
    chk({tag, "_err"}, res_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // n0/n1 raise a new request if that requester is not already holding one.
  // k: WAIT cycle on which the core answers (k >= TMO means never).
  // d: cycles of backpressure before the result is accepted.
  task automatic run_op(input bit n0, input bit n1, input bit fix,
                        input logic [W-1:0] fa, input logic [W-1:0] fb,
                        input int k, input int d, input bit junk);
    bit            w;
    logic [W-1:0]  ea, eb;
    logic [PW-1:0] prod, ep;
    bit            eerr;
    @(negedge clk);
    ready = 1'b0;
    done  = 1'b0;
    if (n0 && !req0) begin
      req0 = 1'b1;
      a0 = fix ? fa : W'($urandom);
      b0 = fix ? fb : W'($urandom);
    end
    if (n1 && !req1) begin
      req1 = 1'b1;
      a1 = fix ? fa : W'($urandom);
      b1 = fix ? fb : W'($urandom);
    end
    if (!req0 && !req1) begin
      req0 = 1'b1;
      a0 = W'($urandom);
      b0 = W'($urandom);
    end
    w  = (req0 && req1) ? !last_g : req1;
    ea = w ? a1 : a0;
    eb = w ? b1 : b0;
    prod = PW'(ea) * PW'(eb);
    eerr = (k >= TMO);
    ep   = eerr ? '0 : prod;
    @(posedge clk); #1;
    chk("gnt0", gnt0, !w);
    chk("gnt1", gnt1, w);
    chk("start", mul_start, 1);
    chk("mul_a", mul_a, ea);
    chk("mul_b", mul_b, eb);
    chk("busy_load", busy, 1);
    last_g = w;
    @(negedge clk);
    if (w) req1 = 1'b0;
    else   req0 = 1'b0;
    if (junk) begin
      done  = 1'b1;
      mul_p = PW'($urandom);
    end
    @(posedge clk); #1;
    chk("start_once", mul_start, 0);
    chk("gnt_once", gnt0 | gnt1, 0);
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      done  = (i == k);
      mul_p = (i == k) ? prod : PW'($urandom);
      @(posedge clk); #1;
      if (i == k || i == TMO - 1) begin
        chk("valid_rise", res_valid, 1);
        break;
      end
      chk("no_valid", res_valid, 0);
    end
    chk("res_id", res_id, w);
    chk("res_p", res_p, ep);
    chk("res_err", res_err, eerr);
    for (int j = 0; j < d; j++) begin
      @(negedge clk);
      done  = junk;
      mul_p = PW'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", res_valid, 1);
      chk("hold_id", res_id, w);
      chk("hold_p", res_p, ep);
      chk("hold_err", res_err, eerr);
      chk("hold_nognt", gnt0 | gnt1, 0);
      chk("hold_busy", busy, 1);
      chk("hold_mul_a", mul_a, ea);
    end
    @(negedge clk);
    done  = 1'b0;
    ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_fall", res_valid, 0);
    chk("idle", busy, 0);
  endtask

  initial begin
    #12;
    chk_zero("rst");
    @(negedge clk);
    rst = 1'b1;

    run_op(1, 1, 0, '0, '0, 3, 0, 0);
    run_op(0, 0, 0, '0, '0, 5, 1, 0);
    run_op(1, 0, 1, 16'h0003, 16'h0005, 15, 0, 0);
    run_op(0, 1, 0, '0, '0, TMO + 5, 0, 0);
    run_op(1, 0, 0, '0, '0, TMO - 1, 0, 1);
    run_op(1, 1, 0, '0, '0, 4, 10, 1);
    run_op(0, 0, 0, '0, '0, 2, 0, 0);
    run_op(1, 0, 1, 16'hFFFF, 16'hFFFF, 7, 2, 0);
    run_op(0, 1, 0, '0, '0, 0, 0, 0);

    // Drop reset in WAIT cycle 5; the core's late answer must vanish.
    @(negedge clk);
    ready = 1'b0;
    req1  = 1'b0;
    req0  = 1'b1;
    a0 = W'($urandom);
    b0 = W'($urandom);
    @(posedge clk); #1;
    chk("rw_gnt0", gnt0, 1);
    @(negedge clk);
    req0 = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero("rw");
    last_g = 1'b1;
    @(negedge clk);
    rst   = 1'b1;
    done  = 1'b1;
    mul_p = PW'($urandom);
    @(posedge clk); #1;
    chk("late_valid", res_valid, 0);
    chk("late_busy", busy, 0);
    run_op(1, 1, 0, '0, '0, 6, 0, 0);

    for (int n = 0; n < 30; n++) begin
      int r, k;
      r = int'($urandom % 8);
      if (r == 0)      k = TMO + int'($urandom % 3);
      else if (r == 1) k = TMO - 1;
      else             k = int'($urandom % TMO);
      run_op(bit'($urandom % 2), bit'($urandom % 2), 0, '0, '0, k,
             int'($urandom % 4), bit'($urandom % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_sched.md
MUL_SCHED -- requirements
Module: mul_sched

Parameters
REQ-001 SHALL provide parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL provide parameter TMO, default 20, maximum number of WAIT cycles before timeout.

Interface
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 req0_i / req1_i  in  1  operation request, requester 0 / 1.
REQ-006 a0_i, b0_i / a1_i, b1_i  in  WIDTH  operands, requester 0 / 1.
REQ-007 gnt0_o / gnt1_o  out  1  one-cycle grant pulse; operands captured on that cycle.
REQ-008 mul_start_o  out  1  one-cycle start pulse to shared multiplier core.
REQ-009 mul_a_o, mul_b_o  out  WIDTH  registered operands to core, stable from start until the next grant.
REQ-010 mul_done_i  in  1  core completion strobe.
REQ-011 mul_p_i  in  2*WIDTH  core product, valid when mul_done_i=1.
REQ-012 res_valid_o  out  1  result available.
REQ-013 res_id_o  out  1  requester that owns the result.
REQ-014 res_p_o  out  2*WIDTH  captured product.
REQ-015 res_err_o  out  1  result produced by timeout, not by the core.
REQ-016 res_ready_i  in  1  result consumer accepts.
REQ-017 busy_o  out  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, WAIT and OUT.
REQ-019 In IDLE with any req high at a rising edge: go to LOAD, latch the winner's operands into mul_a_o/mul_b_o, record the winner as owner.
REQ-020 Arbitration SHALL be round-robin: single request wins; on simultaneous requests, the requester not granted last wins.
REQ-021 The last-granted pointer SHALL update only on a grant.
REQ-022 In LOAD: the owner's gnt SHALL be high and mul_start_o high for exactly that one cycle; the next state SHALL be WAIT unconditionally.
REQ-023 A requester SHALL hold req and operands until it sees its gnt; a req still high after gnt is treated as a new request.
REQ-024 In WAIT: the cycle counter SHALL start at 0 on entry and increment each cycle.
REQ-025 In WAIT, mul_done_i=1 SHALL capture mul_p_i into res_p_o, clear res_err_o and go to OUT.
REQ-026 In WAIT with counter=TMO-1 and mul_done_i=0: res_p_o SHALL be set to 0, res_err_o to 1, and the state SHALL go to OUT.
REQ-027 If mul_done_i=1 on the timeout cycle, the done SHALL win.
REQ-028 mul_done_i SHALL be ignored in IDLE, LOAD and OUT.
REQ-029 In OUT: res_valid_o=1, and res_id_o, res_p_o and res_err_o SHALL be held stable until res_ready_i=1.
REQ-030 At the OUT edge with res_ready_i=1, the state SHALL go to IDLE; the minimum spacing between grants is therefore 4 cycles plus the core latency.
REQ-031 Requests arriving outside IDLE SHALL wait, and are never lost while held.
REQ-032 Result latency SHALL be: res_valid_o rises 1 cycle after the mul_done_i edge, and the start-to-valid time is core latency + 1.

Reset
REQ-033 rst_i=0 SHALL immediately force the following, regardless of clock: state=IDLE, all outputs 0 (gnt*, mul_start_o, mul_a_o, mul_b_o, res_valid_o, res_id_o, res_p_o, res_err_o, busy_o), counter=0, last-granted=1 (so requester 0 has first priority).
REQ-034 Reset asserted mid-operation (LOAD/WAIT/OUT) SHALL discard the operation with no result; a late mul_done_i after reset SHALL be ignored.
REQ-035 After rst_i rises, the first rising edge SHALL evaluate requests normally.

Verification
REQ-036 Single request: req0=1, a0=16'h0003, b0=16'h0005, core returns 32'h0000000F after 16 cycles -> gnt0 pulse, mul_start pulse, res_valid with id=0, p=15, err=0.
REQ-037 Simultaneous requests after reset: req0=req1=1 -> grant 0 first, then grant 1 after the result is accepted.
REQ-038 Timeout: core never asserts done, TMO=20 -> res_valid exactly 20 cycles after WAIT entry, p=0, err=1.
REQ-039 Backpressure: hold res_ready=0 for 10 cycles with a new req1 pending -> result stable, no gnt1, busy=1; grant issued only after acceptance.
REQ-040 Reset mid-WAIT: assert rst_i=0 at WAIT cycle 5, then core done -> all outputs 0, no res_valid, next grant goes to requester 0.
REQ-041 Edge operands: a=b=16'hFFFF, core returns 32'hFFFE0001 -> res_p_o=32'hFFFE0001 unchanged.
